// File: rtl/line_steer_ctrl_if.sv
// Sensor/steering bundle between the line-following controller and its environment.
interface line_steer_ctrl_if;
    logic [5:0] sens;
    logic       direction;
    logic       enable;
    logic [3:0] dir;
    logic       dir_upd;
    logic [1:0] state_o;
    logic [7:0] isect_cnt;

    modport master (output sens, direction, enable,
                    input  dir, dir_upd, state_o, isect_cnt);
    modport slave  (input  sens, direction, enable,
                    output dir, dir_upd, state_o, isect_cnt);
endinterface

// File: rtl/line_steer_ctrl.sv
// Line-following steering controller: sensor sync/debounce, track/intersection/lost FSM.
// Optional macro LOST_RECOVERY_EN: timed NINETY search toward the last correction side in LOST.
module line_steer_ctrl #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned DEBOUNCE_CYCLES  = 250000,
    parameter int unsigned INTERSECT_CYCLES = 25000000,
    parameter int unsigned LOST_CYCLES      = 50000000,
    parameter int unsigned ACTIVE_LOW       = 1,
    parameter int unsigned TURN_HARD        = 1
) (
    input  logic              clk,
    input  logic              rst,
    line_steer_ctrl_if.slave  bus
);
    localparam int unsigned SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned DEB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DEB_LAST = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES - 2 : 0;
    // One timer serves both INTERSECT and LOST, so it is sized for the larger limit.
    localparam int unsigned TMR_MAX  = (LOST_CYCLES > INTERSECT_CYCLES) ? LOST_CYCLES : INTERSECT_CYCLES;
    localparam int unsigned TMR_W    = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

    localparam logic [3:0] D_PROCEED  = 4'b0000;
    localparam logic [3:0] D_VEER_R   = 4'b1001;
    localparam logic [3:0] D_HARD_R   = 4'b1010;
    localparam logic [3:0] D_NINETY_R = 4'b1011;
    localparam logic [3:0] D_VEER_L   = 4'b0101;
    localparam logic [3:0] D_HARD_L   = 4'b0110;
    localparam logic [3:0] D_NINETY_L = 4'b0111;
    localparam logic [3:0] D_STOP     = 4'b1111;
    localparam logic [3:0] R_CORR     = (TURN_HARD != 0) ? D_HARD_R : D_VEER_R;
    localparam logic [3:0] L_CORR     = (TURN_HARD != 0) ? D_HARD_L : D_VEER_L;
    localparam logic [5:0] POL_MASK   = (ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TRACK = 2'b01,
        S_ISECT = 2'b10,
        S_LOST  = 2'b11
    } state_t;

    logic [5:0]       sync_q [SYNC_N];
    logic [5:0]       s;
    logic [5:0]       cand;
    logic [5:0]       stable;
    logic [DEB_W-1:0] deb_cnt;
    logic             stable_evt;
    logic             fwd;
    logic             dir_evt;
    logic [1:0]       lead;
    logic [1:0]       mid;
    logic             evt;

    state_t           state, state_nx;
    logic [3:0]       dir_q, dir_nx;
    logic             upd_q;
    logic [7:0]       isect_q, isect_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             reeval, reeval_nx;
`ifdef LOST_RECOVERY_EN
    logic             last_left, last_left_nx;
`endif

    // Metastability synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_N; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= bus.sens;
            for (int i = 1; i < SYNC_N; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_N-1] ^ POL_MASK;

    // Debounce: stable follows s after DEBOUNCE_CYCLES consecutive equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand       <= '0;
            stable     <= '0;
            deb_cnt    <= '0;
            stable_evt <= 1'b0;
            fwd        <= 1'b0;
            dir_evt    <= 1'b0;
        end else begin
            stable_evt <= 1'b0;
            fwd        <= bus.direction;
            dir_evt    <= (bus.direction != fwd);
            if (s != cand) begin
                cand    <= s;
                deb_cnt <= '0;
            end else if (cand != stable) begin
                if (deb_cnt >= DEB_W'(DEB_LAST)) begin
                    stable     <= cand;
                    deb_cnt    <= '0;
                    stable_evt <= 1'b1;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end
        end
    end

    assign lead = fwd ? stable[5:4] : stable[1:0];
    assign mid  = stable[3:2];
    assign evt  = stable_evt | dir_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dir_q     <= D_STOP;
            upd_q     <= 1'b0;
            isect_q   <= '0;
            tmr       <= '0;
            reeval    <= 1'b0;
`ifdef LOST_RECOVERY_EN
            last_left <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            dir_q     <= dir_nx;
            upd_q     <= (dir_nx != dir_q);
            isect_q   <= isect_nx;
            tmr       <= tmr_nx;
            reeval    <= reeval_nx;
`ifdef LOST_RECOVERY_EN
            last_left <= last_left_nx;
`endif
        end
    end

    always_comb begin
        state_nx  = state;
        dir_nx    = dir_q;
        isect_nx  = isect_q;
        tmr_nx    = tmr;
        reeval_nx = 1'b0;
`ifdef LOST_RECOVERY_EN
        last_left_nx = last_left;
`endif
        if (!bus.enable) begin
            state_nx = S_IDLE;
            dir_nx   = D_STOP;
        end else begin
            case (state)
                S_IDLE: begin
                    dir_nx    = D_STOP;
                    state_nx  = S_TRACK;
                    reeval_nx = 1'b1;
                end
                S_TRACK: begin
                    if (evt || reeval) begin
                        case (lead)
                            2'b11: dir_nx = D_PROCEED;
                            2'b10: begin
                                dir_nx = R_CORR;
`ifdef LOST_RECOVERY_EN
                                last_left_nx = 1'b0;
`endif
                            end
                            2'b01: begin
                                dir_nx = L_CORR;
`ifdef LOST_RECOVERY_EN
                                last_left_nx = 1'b1;
`endif
                            end
                            default: begin
                                dir_nx   = D_PROCEED;
                                tmr_nx   = '0;
                                state_nx = S_ISECT;
                            end
                        endcase
                    end
                end
                S_ISECT: begin
                    tmr_nx = tmr + TMR_W'(1);
                    if (mid == 2'b11) begin
                        dir_nx   = D_STOP;
                        isect_nx = isect_q + 8'd1;
                        state_nx = S_TRACK;
                    end else if (lead != 2'b00 || dir_evt) begin
                        state_nx  = S_TRACK;
                        reeval_nx = 1'b1;
                    end else if (tmr == TMR_W'(INTERSECT_CYCLES - 1)) begin
                        state_nx = S_LOST;
                        tmr_nx   = '0;
`ifdef LOST_RECOVERY_EN
                        dir_nx   = last_left ? D_NINETY_L : D_NINETY_R;
`else
                        dir_nx   = D_STOP;
`endif
                    end else if (mid == 2'b01) begin
                        dir_nx = fwd ? D_NINETY_L : D_NINETY_R;
                    end else if (mid == 2'b10) begin
                        dir_nx = fwd ? D_NINETY_R : D_NINETY_L;
                    end
                end
                S_LOST: begin
                    if (lead != 2'b00) begin
                        state_nx  = S_TRACK;
                        reeval_nx = 1'b1;
                    end else begin
`ifdef LOST_RECOVERY_EN
                        // Keep turning until LOST_CYCLES of NINETY have been issued.
                        if (tmr < TMR_W'(LOST_CYCLES - 1)) begin
                            tmr_nx = tmr + TMR_W'(1);
                            dir_nx = last_left ? D_NINETY_L : D_NINETY_R;
                        end else begin
                            dir_nx = D_STOP;
                        end
`else
                        dir_nx = D_STOP;
`endif
                    end
                end
            endcase
        end
    end

    assign bus.dir       = dir_q;
    assign bus.dir_upd   = upd_q;
    assign bus.state_o   = state;
    assign bus.isect_cnt = isect_q;
endmodule

// File: tb/tb_line_steer_ctrl.sv
// Directed bench for line_steer_ctrl (SYNC=2, DEB=4, ISECT=20, LOST=10, active-low sensors).
module tb_line_steer_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks  = 0;
    int   errors  = 0;
    int   upd_cnt = 0;

    line_steer_ctrl_if bus ();

    line_steer_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INTERSECT_CYCLES(20),
        .LOST_CYCLES(10), .ACTIVE_LOW(1), .TURN_HARD(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.dir_upd === 1'b1) upd_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.direction = 1'b1;
        bus.sens = 6'b000000;
        run(3);
        chk("rst_dir", 8'(bus.dir), 8'hF);
        chk("rst_state", 8'(bus.state_o), 8'h0);
        chk("rst_cnt", bus.isect_cnt, 8'h0);
        chk("rst_upd", 8'(bus.dir_upd), 8'h0);

        rst = 1'b0;
        run(10);
        chk("idle_state", 8'(bus.state_o), 8'h0);
        upd_cnt = 0;
        bus.enable = 1'b1;
        run(4);
        chk("en_state", 8'(bus.state_o), 8'h1);
        chk("en_dir", 8'(bus.dir), 8'h0);
        chk("en_upd_pulses", 8'(upd_cnt), 8'd1);

        // LF off line: HARD_R after exactly 7 clocks
        upd_cnt = 0;
        bus.sens = 6'b010000;
        run(6);
        chk("lat_before", 8'(bus.dir), 8'h0);
        run(1);
        chk("lat_at7", 8'(bus.dir), 8'hA);
        chk("lat_upd", 8'(upd_cnt), 8'd1);

        upd_cnt = 0;
        bus.sens = 6'b110000;
        run(2);
        bus.sens = 6'b010000;
        run(12);
        chk("glitch_dir", 8'(bus.dir), 8'hA);
        chk("glitch_upd", 8'(upd_cnt), 8'd0);

        // Forward intersection with left branch, then crossing bar
        bus.sens = 6'b111000;
        run(9);
        chk("isect_state", 8'(bus.state_o), 8'h2);
        chk("isect_ninety_l", 8'(bus.dir), 8'h7);
        bus.sens = 6'b110000;
        run(9);
        chk("cross_dir", 8'(bus.dir), 8'hF);
        chk("cross_cnt", bus.isect_cnt, 8'd1);
        chk("cross_state", 8'(bus.state_o), 8'h1);

        // Backward tracking and mirrored turn
        bus.direction = 1'b0;
        run(3);
        chk("bwd_dir", 8'(bus.dir), 8'h0);
        bus.sens = 6'b010111;
        run(9);
        chk("bwd_isect_state", 8'(bus.state_o), 8'h2);
        chk("bwd_ninety", 8'(bus.dir), 8'h7);
        bus.direction = 1'b1;
        run(4);
        chk("toggle_state", 8'(bus.state_o), 8'h1);
        chk("toggle_front_eval", 8'(bus.dir), 8'hA);

        bus.sens = 6'b100111;
        run(8);
        chk("hard_l", 8'(bus.dir), 8'h6);

        // Line loss: 20 cycles in INTERSECT then LOST
        bus.sens = 6'b111100;
        run(9);
        chk("loss_isect", 8'(bus.state_o), 8'h2);
        chk("loss_hold", 8'(bus.dir), 8'h0);
        run(17);
        chk("loss_edge_m1", 8'(bus.state_o), 8'h2);
        run(1);
        chk("loss_edge", 8'(bus.state_o), 8'h3);
`ifdef LOST_RECOVERY_EN
        chk("lost_first", 8'(bus.dir), 8'h7);
        run(9);
        chk("lost_last", 8'(bus.dir), 8'h7);
        run(1);
        chk("lost_stop", 8'(bus.dir), 8'hF);
`else
        chk("lost_first", 8'(bus.dir), 8'hF);
        run(10);
        chk("lost_stop", 8'(bus.dir), 8'hF);
`endif
        bus.sens = 6'b001100;
        run(9);
        chk("reacq_state", 8'(bus.state_o), 8'h1);
        chk("reacq_dir", 8'(bus.dir), 8'h0);

        bus.enable = 1'b0;
        run(1);
        chk("dis_state", 8'(bus.state_o), 8'h0);
        chk("dis_dir", 8'(bus.dir), 8'hF);
        bus.enable = 1'b1;
        run(3);
        chk("reen_dir", 8'(bus.dir), 8'h0);

        // Four more crossings, then reset mid-intersection
        for (int i = 0; i < 4; i++) begin
            bus.sens = 6'b110000;
            run(9);
            bus.sens = 6'b000000;
            run(9);
        end
        chk("cnt5", bus.isect_cnt, 8'd5);
        bus.sens = 6'b111100;
        run(9);
        chk("pre_rst_state", 8'(bus.state_o), 8'h2);
        rst = 1'b1;
        run(1);
        chk("mid_rst_dir", 8'(bus.dir), 8'hF);
        chk("mid_rst_state", 8'(bus.state_o), 8'h0);
        chk("mid_rst_cnt", bus.isect_cnt, 8'd0);

        // Counter wrap 255 -> 0
        bus.enable = 1'b0;
        bus.sens = 6'b000000;
        run(2);
        rst = 1'b0;
        run(10);
        bus.enable = 1'b1;
        run(4);
        for (int i = 0; i < 255; i++) begin
            bus.sens = 6'b110000;
            run(9);
            bus.sens = 6'b000000;
            run(9);
        end
        chk("cnt255", bus.isect_cnt, 8'd255);
        bus.sens = 6'b110000;
        run(9);
        chk("cnt_wrap", bus.isect_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
